// File: rtl/pipe_skid_stage.sv
// Two-entry skid-buffered pipeline register: main entry drives the output, skid
// entry absorbs one payload while downstream stalls so in_ready depends only on state.
module pipe_skid_stage #(
   parameter int unsigned        DATA_W      = 96,
   parameter logic [DATA_W-1:0]  BUBBLE_DATA = {DATA_W{1'b0}},
   parameter int unsigned        CNT_W       = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  drop_cnt
);

   // Handshake: a transfer happens on a rising edge where valid and ready are both
   // high; valid must not depend on ready, and a held payload stays stable until taken.

   logic              main_valid, main_valid_n;
   logic [DATA_W-1:0] main_data, main_data_n;
   logic              skid_valid, skid_valid_n;
   logic [DATA_W-1:0] skid_data, skid_data_n;
   logic [1:0]        occupancy_n;
   logic [CNT_W-1:0]  drop_cnt_n;
   logic [1:0]        dropped;
   logic [CNT_W:0]    drop_sum;
   logic              in_fire, out_fire;

   assign in_ready  = !skid_valid;
   assign out_valid = main_valid;
   assign out_data  = main_valid ? main_data : BUBBLE_DATA;
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = main_valid & out_ready;

   // Entries still held after this cycle's delivery are the ones a flush discards.
   assign dropped  = {1'b0, main_valid & !out_fire} + {1'b0, skid_valid};
   assign drop_sum = {1'b0, drop_cnt} + {{(CNT_W - 1){1'b0}}, dropped};

   always_comb begin
      main_valid_n = main_valid;
      main_data_n  = main_data;
      skid_valid_n = skid_valid;
      skid_data_n  = skid_data;
      drop_cnt_n   = drop_cnt;

      if (flush) begin
         main_valid_n = 1'b0;
         main_data_n  = BUBBLE_DATA;
         skid_valid_n = 1'b0;
         drop_cnt_n   = drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
      end else if (out_fire) begin
         if (skid_valid) begin
            main_valid_n = 1'b1;
            main_data_n  = skid_data;
            skid_valid_n = 1'b0;
         end else if (in_fire) begin
            main_valid_n = 1'b1;
            main_data_n  = in_data;
         end else begin
            main_valid_n = 1'b0;
            main_data_n  = BUBBLE_DATA;
         end
      end else if (in_fire) begin
         if (!main_valid) begin
            main_valid_n = 1'b1;
            main_data_n  = in_data;
         end else begin
            skid_valid_n = 1'b1;
            skid_data_n  = in_data;
         end
      end

      occupancy_n = {1'b0, main_valid_n} + {1'b0, skid_valid_n};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         main_valid <= 1'b0;
         main_data  <= BUBBLE_DATA;
         skid_valid <= 1'b0;
         skid_data  <= BUBBLE_DATA;
         occupancy  <= 2'd0;
         drop_cnt   <= '0;
      end else begin
         main_valid <= main_valid_n;
         main_data  <= main_data_n;
         skid_valid <= skid_valid_n;
         skid_data  <= skid_data_n;
         occupancy  <= occupancy_n;
         drop_cnt   <= drop_cnt_n;
      end
   end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed bench for pipe_skid_stage: stream, stall, flush, saturation and reset cases,
// with a second instance using a 2-bit drop counter sharing the same stimulus.
module tb_pipe_skid_stage;

   localparam int unsigned DATA_W = 96;
   localparam logic [DATA_W-1:0] BUB = 96'hB0B0_B0B0_0000_0000_5A5A_5A5A;

   logic              clk = 1'b0;
   logic              reset, flush, in_valid, out_ready;
   logic [DATA_W-1:0] in_data;
   logic              in_ready, out_valid;
   logic [DATA_W-1:0] out_data;
   logic [1:0]        occupancy;
   logic [15:0]       drop_cnt;
   logic              s_in_ready, s_out_valid;
   logic [DATA_W-1:0] s_out_data;
   logic [1:0]        s_occupancy;
   logic [1:0]        s_drop_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipe_skid_stage #(.DATA_W(DATA_W), .BUBBLE_DATA(BUB), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
      .out_ready(out_ready), .occupancy(occupancy), .drop_cnt(drop_cnt)
   );

   pipe_skid_stage #(.DATA_W(DATA_W), .BUBBLE_DATA(BUB), .CNT_W(2)) dut_sat (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_data(in_data),
      .in_ready(s_in_ready), .out_valid(s_out_valid), .out_data(s_out_data),
      .out_ready(out_ready), .occupancy(s_occupancy), .drop_cnt(s_drop_cnt)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_state(input string tag, input logic ov, input logic [DATA_W-1:0] od,
                            input logic ir, input logic [1:0] occ);
      chk({tag, ".out_valid"}, 128'(out_valid), 128'(ov));
      chk({tag, ".out_data"},  128'(out_data),  128'(od));
      chk({tag, ".in_ready"},  128'(in_ready),  128'(ir));
      chk({tag, ".occupancy"}, 128'(occupancy), 128'(occ));
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      step();
      step();
      chk_state("reset", 1'b0, BUB, 1'b1, 2'd0);
      chk("reset.drop_cnt", 128'(drop_cnt), 128'd0);
      reset = 1'b0;

      // Stream: one payload per cycle, one cycle latency.
      out_ready = 1'b1; in_valid = 1'b1;
      in_data = 96'd1; step(); chk_state("stream1", 1'b1, 96'd1, 1'b1, 2'd1);
      in_data = 96'd2; step(); chk_state("stream2", 1'b1, 96'd2, 1'b1, 2'd1);
      in_data = 96'd3; step(); chk_state("stream3", 1'b1, 96'd3, 1'b1, 2'd1);
      in_valid = 1'b0; step(); chk_state("stream_end", 1'b0, BUB, 1'b1, 2'd0);

      // Stall: A then B accepted while downstream is blocked.
      out_ready = 1'b0; in_valid = 1'b1;
      in_data = 96'hA; step(); chk_state("stall_a", 1'b1, 96'hA, 1'b1, 2'd1);
      in_data = 96'hB; step(); chk_state("stall_ab", 1'b1, 96'hA, 1'b0, 2'd2);
      in_data = 96'hE; step(); chk_state("stall_hold", 1'b1, 96'hA, 1'b0, 2'd2);
      in_valid = 1'b0; out_ready = 1'b1;
      step(); chk_state("drain_b", 1'b1, 96'hB, 1'b1, 2'd1);
      step(); chk_state("drain_end", 1'b0, BUB, 1'b1, 2'd0);

      // Flush full with a coinciding input that must be discarded.
      out_ready = 1'b0; in_valid = 1'b1;
      in_data = 96'h10; step();
      in_data = 96'h11; step(); chk_state("fill", 1'b1, 96'h10, 1'b0, 2'd2);
      flush = 1'b1; in_data = 96'hC; step();
      flush = 1'b0; in_valid = 1'b0;
      chk_state("flush_full", 1'b0, BUB, 1'b1, 2'd0);
      chk("flush_full.drop_cnt", 128'(drop_cnt), 128'd2);
      out_ready = 1'b1; step();
      chk_state("flush_no_c", 1'b0, BUB, 1'b1, 2'd0);

      // Flush coinciding with delivery of the only entry.
      in_valid = 1'b1; in_data = 96'h20; step();
      chk_state("one_entry", 1'b1, 96'h20, 1'b1, 2'd1);
      in_valid = 1'b0; flush = 1'b1; step(); flush = 1'b0;
      chk_state("flush_drain", 1'b0, BUB, 1'b1, 2'd0);
      chk("flush_drain.drop_cnt", 128'(drop_cnt), 128'd2);

      // Flush with two entries while main is delivered: only skid is dropped.
      out_ready = 1'b0; in_valid = 1'b1;
      in_data = 96'h30; step();
      in_data = 96'h31; step();
      in_valid = 1'b0; out_ready = 1'b1; flush = 1'b1; step(); flush = 1'b0;
      chk_state("flush_partial", 1'b0, BUB, 1'b1, 2'd0);
      chk("flush_partial.drop_cnt", 128'(drop_cnt), 128'd3);
      chk("flush_partial.sat_cnt", 128'(s_drop_cnt), 128'd3);

      // Reset mid-stall discards entries and clears the counter.
      out_ready = 1'b0; in_valid = 1'b1;
      in_data = 96'h40; step();
      in_data = 96'h41; step(); chk("pre_reset.occupancy", 128'(occupancy), 128'd2);
      in_valid = 1'b0; reset = 1'b1; step(); reset = 1'b0;
      chk_state("reset_mid", 1'b0, BUB, 1'b1, 2'd0);
      chk("reset_mid.drop_cnt", 128'(drop_cnt), 128'd0);
      chk("reset_mid.sat_cnt", 128'(s_drop_cnt), 128'd0);

      // Four full flushes: the 2-bit counter saturates at 3.
      for (int i = 0; i < 4; i++) begin
         out_ready = 1'b0; in_valid = 1'b1;
         in_data = 96'(32'h50 + 2 * i); step();
         in_data = 96'(32'h51 + 2 * i); step();
         in_valid = 1'b0; flush = 1'b1; step(); flush = 1'b0;
      end
      chk("sat.drop_cnt", 128'(s_drop_cnt), 128'd3);
      chk("wide.drop_cnt", 128'(drop_cnt), 128'd8);
      chk("sat.occupancy", 128'(s_occupancy), 128'd0);

      // Stage is still usable after the flushes.
      out_ready = 1'b1; in_valid = 1'b1; in_data = 96'h77; step(); in_valid = 1'b0;
      chk_state("post_flush", 1'b1, 96'h77, 1'b1, 2'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
